programmable_logic_unit: RTL
============================

PROGRAMMABLE_LOGIC_UNIT -- requirements
Module: programmable_logic_unit

Interface
REQ-001 The block SHALL have parameter N_IN, default 3, giving the number of logic inputs (legal range 1..6).
REQ-002 The block SHALL have parameter TT_INIT, width 2**N_IN, default 8'hF0, giving the truth table loaded at reset (default gives F = MSB input).
REQ-003 The block SHALL have parameter CNT_W, default 8, giving the evaluation-counter width.
REQ-004 The block SHALL run on one clock and SHALL use a synchronous, active-low reset; no other clock or reset exists.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-007 cfg_en  input  1  high = shift truth-table bits in; must stay high for the whole load.
REQ-008 cfg_bit  input  1  serial truth-table bit, MSB (entry 2**N_IN-1) first, one per cycle while cfg_en=1.
REQ-009 in_valid  input  1  in_data is valid this cycle.
REQ-010 in_data  input  N_IN  input vector; in_data[N_IN-1] is A, in_data[N_IN-2] is B, and so on.
REQ-011 f  output  1  registered result, table[in_data].
REQ-012 out_valid  output  1  f is valid this cycle.
REQ-013 cfg_done  output  1  one-cycle pulse: new table committed.
REQ-014 busy  output  1  high while in LOAD state.
REQ-015 in_drop  output  1  one-cycle pulse: an in_valid was discarded.
REQ-016 eval_count  output  CNT_W  number of evaluations performed, saturating.

Function
REQ-017 The FSM SHALL have two states: RUN and LOAD; reset state is RUN.
REQ-018 RUN->LOAD SHALL occur on a cycle with cfg_en=1; cfg_bit of that same cycle is shifted as the first bit.
REQ-019 In LOAD, each cycle with cfg_en=1 SHALL shift cfg_bit into a shadow register and increment a bit counter (0..2**N_IN-1).
REQ-020 When the 2**N_IN-th bit is shifted, the block SHALL copy shadow to the active table, pulse cfg_done on the next cycle, clear the counter, and return to RUN.
REQ-021 If cfg_en falls in LOAD before the last bit, the block SHALL abort: active table unchanged, counter cleared, no cfg_done, return to RUN on the next cycle.
REQ-022 busy SHALL equal (state == LOAD).
REQ-023 In RUN with in_valid=1 and cfg_en=0, the block SHALL register f = active_table[in_data] and assert out_valid exactly one cycle later (latency 1).
REQ-024 Back-to-back in_valid SHALL give back-to-back out_valid with no bubbles.
REQ-025 in_valid=1 while in LOAD, or together with cfg_en=1 in RUN, SHALL be discarded (no out_valid), and in_drop SHALL pulse the next cycle.
REQ-026 Evaluation SHALL use the table active in the in_valid cycle; a commit in the same cycle affects only later inputs.
REQ-027 f SHALL hold its last value when out_valid=0.
REQ-028 eval_count SHALL increment on every out_valid and saturate at 2**CNT_W-1 (no wrap).
REQ-029 cfg_en held high after the final bit SHALL start a new load in the cycle after commit.

Reset
REQ-030 On rst_n=0 at a clock edge, the block SHALL reset: state=RUN, active table=TT_INIT, shadow=0, counter=0, f=0, out_valid=0, cfg_done=0, busy=0, in_drop=0, eval_count=0.
REQ-031 Reset mid-LOAD SHALL discard the partial load; the table returns to TT_INIT, not the last committed table.
REQ-032 Reset SHALL override all inputs in the same cycle.

Verification
REQ-033 Default table: after reset, in_valid=1 with in_data=3'b100 -> next cycle out_valid=1, f=1, eval_count=1.
REQ-034 Load 8'b0110_1001 (XNOR3) over 8 cycles -> cfg_done pulses once, busy low after; in_data=3'b111 -> f=0, 3'b110 -> f=1.
REQ-035 Abort: cfg_en high for 4 bits then low -> no cfg_done; in_data=3'b100 -> f=1 (TT_INIT kept).
REQ-036 in_valid with cfg_en=1 -> no out_valid, in_drop=1 next cycle, eval_count unchanged.
REQ-037 CNT_W=2, 5 back-to-back valid inputs -> 5 consecutive out_valid, eval_count stops at 3.
REQ-038 rst_n=0 after 5 load bits of a custom table -> all outputs 0, table=TT_INIT (3'b100 -> f=1).

Source files
------------

// File: rtl/programmable_logic_unit.sv
// Serially reconfigurable N_IN-input lookup table with a registered evaluation path.
// The truth table is shifted in MSB-first through a shadow register and committed atomically.
module programmable_logic_unit #(
  parameter int                   N_IN    = 3,
  parameter logic [(1<<N_IN)-1:0] TT_INIT = 8'hF0,
  parameter int                   CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_en,
  input  logic             i_cfg_bit,
  input  logic             i_in_valid,
  input  logic [N_IN-1:0]  i_in_data,
  output logic             o_f,
  output logic             o_out_valid,
  output logic             o_cfg_done,
  output logic             o_busy,
  output logic             o_in_drop,
  output logic [CNT_W-1:0] o_eval_count
);

  localparam int TT_W = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [TT_W-1:0]   r_table;
  logic [TT_W-1:0]   r_shadow;
  logic [N_IN-1:0]   r_bit_cnt;
  logic              r_f;
  logic              r_out_valid;
  logic              r_cfg_done;
  logic              r_in_drop;
  logic [CNT_W-1:0]  r_eval_count;

  logic              w_busy;
  logic              w_commit;
  logic              w_eval;
  logic              w_drop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:  if (i_cfg_en) w_state_next = S_LOAD;
      S_LOAD: if (!i_cfg_en || r_bit_cnt == LAST_IDX) w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  // r_bit_cnt counts bits already shifted; the LOAD cycle that sees LAST_IDX carries the final bit.
  always_comb begin
    w_busy   = (r_state == S_LOAD);
    w_commit = w_busy && i_cfg_en && (r_bit_cnt == LAST_IDX);
    w_eval   = !w_busy && i_in_valid && !i_cfg_en;
    w_drop   = i_in_valid && !w_eval;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_table      <= TT_INIT;
      r_shadow     <= '0;
      r_bit_cnt    <= '0;
      r_f          <= 1'b0;
      r_out_valid  <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_in_drop    <= 1'b0;
      r_eval_count <= '0;
    end else begin
      if (i_cfg_en) begin
        r_shadow <= {r_shadow[TT_W-2:0], i_cfg_bit};
      end
      if (!i_cfg_en || w_commit) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + N_IN'(1);
      end
      if (w_commit) begin
        r_table <= {r_shadow[TT_W-2:0], i_cfg_bit};
      end
      r_cfg_done  <= w_commit;
      r_in_drop   <= w_drop;
      r_out_valid <= w_eval;
      if (w_eval) begin
        r_f <= r_table[i_in_data];
        if (r_eval_count != '1) begin
          r_eval_count <= r_eval_count + CNT_W'(1);
        end
      end
    end
  end

  assign o_f          = r_f;
  assign o_out_valid  = r_out_valid;
  assign o_cfg_done   = r_cfg_done;
  assign o_busy       = w_busy;
  assign o_in_drop    = r_in_drop;
  assign o_eval_count = r_eval_count;

endmodule
